// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war round scheduler: FSM states and winner encodings.
package tug_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCountdown,
    StPlay,
    StRoundOver,
    StMatchOver
  } state_e;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  // True once a player's round count has reached the match-winning total.
  function automatic logic at_match_point(logic [2:0] score, int unsigned win_score);
    return score == 3'(win_score);
  endfunction

endpackage

// File: rtl/score_counter.sv
// Saturating 3-bit round-win counter with synchronous clear and increment.
module score_counter #(
  parameter int unsigned WIN_SCORE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] score
);

  logic [2:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (clr) begin
      score_d = 3'd0;
    end else if (inc && (score_q != 3'(WIN_SCORE))) begin
      score_d = score_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= 3'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: rtl/round_scheduler.sv
// Match/round sequencer for a tug-of-war light game.
// Define ROUND_TIMEOUT_EN to end a stalled round as a draw after TIMEOUT_TICKS ticks.
module round_scheduler
  import tug_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 3,
  parameter int unsigned COUNT_TICKS = 3,
  parameter int unsigned HOLD_TICKS  = 2
`ifdef ROUND_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_TICKS = 30
`endif
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       tick,
  input  logic       start,
  input  logic       leftWin,
  input  logic       rightWin,
  output logic       restartGame,
  output logic       playEnable,
  output logic [2:0] scoreL,
  output logic [2:0] scoreR,
  output logic [1:0] winner
);

  localparam int unsigned MaxLoad = (COUNT_TICKS > HOLD_TICKS) ? COUNT_TICKS : HOLD_TICKS;
  localparam int unsigned CntW    = (MaxLoad < 2) ? 1 : $clog2(MaxLoad + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      winner_q, winner_d;
  logic            restart_q, restart_d;
  logic            play_en_q;
  logic            inc_l, inc_r, clr_scores;

`ifdef ROUND_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);

  logic [ToW-1:0] to_cnt_q;
  logic           timeout;

  // Counts ticks spent in the current PLAY stint; cleared whenever PLAY is not active.
  always_ff @(posedge Clock) begin
    if (Reset || (state_q != StPlay)) begin
      to_cnt_q <= '0;
    end else if (tick) begin
      to_cnt_q <= to_cnt_q + ToW'(1);
    end
  end

  assign timeout = (state_q == StPlay) && tick && (to_cnt_q == ToW'(TIMEOUT_TICKS - 1));
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    winner_d   = winner_q;
    restart_d  = 1'b0;
    inc_l      = 1'b0;
    inc_r      = 1'b0;
    clr_scores = 1'b0;

    // Exit events load a fresh count and take precedence over a same-cycle tick.
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = CntW'(COUNT_TICKS);
          state_d = StCountdown;
        end
      end
      StCountdown: begin
        if (tick) begin
          if (cnt_q == '0) begin
            restart_d = 1'b1;
            state_d   = StPlay;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StPlay: begin
        if (leftWin || rightWin) begin
          inc_l   = leftWin && !rightWin;
          inc_r   = rightWin && !leftWin;
          cnt_d   = CntW'(HOLD_TICKS);
          state_d = StRoundOver;
`ifdef ROUND_TIMEOUT_EN
        end else if (timeout) begin
          cnt_d   = CntW'(HOLD_TICKS);
          state_d = StRoundOver;
`endif
        end
      end
      StRoundOver: begin
        if (tick) begin
          if (cnt_q == '0) begin
            if (at_match_point(scoreL, WIN_SCORE)) begin
              winner_d = WIN_LEFT;
              state_d  = StMatchOver;
            end else if (at_match_point(scoreR, WIN_SCORE)) begin
              winner_d = WIN_RIGHT;
              state_d  = StMatchOver;
            end else begin
              cnt_d   = CntW'(COUNT_TICKS);
              state_d = StCountdown;
            end
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StMatchOver: begin
        if (start) begin
          clr_scores = 1'b1;
          winner_d   = WIN_NONE;
          cnt_d      = CntW'(COUNT_TICKS);
          state_d    = StCountdown;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      winner_q  <= WIN_NONE;
      restart_q <= 1'b0;
      play_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      winner_q  <= winner_d;
      restart_q <= restart_d;
      play_en_q <= (state_d == StPlay);
    end
  end

  score_counter #(
    .WIN_SCORE(WIN_SCORE)
  ) u_score_l (
    .clk  (Clock),
    .rst  (Reset),
    .clr  (clr_scores),
    .inc  (inc_l),
    .score(scoreL)
  );

  score_counter #(
    .WIN_SCORE(WIN_SCORE)
  ) u_score_r (
    .clk  (Clock),
    .rst  (Reset),
    .clr  (clr_scores),
    .inc  (inc_r),
    .score(scoreR)
  );

  assign restartGame = restart_q;
  assign playEnable  = play_en_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_round_scheduler.sv
// Directed self-checking bench for round_scheduler with default parameters.
module tb_round_scheduler;
  import tug_pkg::*;

  logic       Clock;
  logic       Reset;
  logic       tick;
  logic       start;
  logic       leftWin;
  logic       rightWin;
  logic       restartGame;
  logic       playEnable;
  logic [2:0] scoreL;
  logic [2:0] scoreR;
  logic [1:0] winner;

  int n_checks = 0;
  int n_errors = 0;

  round_scheduler #(
    .WIN_SCORE  (3),
    .COUNT_TICKS(3),
    .HOLD_TICKS (2)
`ifdef ROUND_TIMEOUT_EN
    ,
    .TIMEOUT_TICKS(5)
`endif
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .tick       (tick),
    .start      (start),
    .leftWin    (leftWin),
    .rightWin   (rightWin),
    .restartGame(restartGame),
    .playEnable (playEnable),
    .scoreL     (scoreL),
    .scoreR     (scoreR),
    .winner     (winner)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_win(input logic l, input logic r);
    leftWin  = l;
    rightWin = r;
    cycle();
    leftWin  = 1'b0;
    rightWin = 1'b0;
  endtask

  // COUNTDOWN loaded with 3 needs four ticks to reach PLAY.
  task automatic to_play();
    repeat (4) do_tick();
  endtask

  // ROUND_OVER loaded with 2 needs three ticks to leave.
  task automatic hold();
    repeat (3) do_tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 32'(dut.state_q), 32'(StIdle));
    check({tag, "_restart"}, 32'(restartGame), 0);
    check({tag, "_play_en"}, 32'(playEnable), 0);
    check({tag, "_score_l"}, 32'(scoreL), 0);
    check({tag, "_score_r"}, 32'(scoreR), 0);
    check({tag, "_winner"}, 32'(winner), 0);
  endtask

  initial begin
    Reset = 1'b1; tick = 1'b1; start = 1'b1; leftWin = 1'b1; rightWin = 1'b0;
    cycle();
    cycle();
    tick = 1'b0; start = 1'b0; leftWin = 1'b0;
    Reset = 1'b0;
    check_idle_outputs("reset");
    check("reset_cnt", 32'(dut.cnt_q), 0);

    // start with a coincident tick: count must load unmodified
    tick = 1'b1;
    do_start();
    tick = 1'b0;
    check("start_state", 32'(dut.state_q), 32'(StCountdown));
    check("start_cnt", 32'(dut.cnt_q), 3);

    // win pulse and start during countdown are ignored
    leftWin = 1'b1;
    do_tick();
    leftWin = 1'b0;
    check("cd_left_ignored", 32'(scoreL), 0);
    do_tick();
    do_tick();
    check("cd_cnt_zero", 32'(dut.cnt_q), 0);
    check("cd_no_restart", 32'(restartGame), 0);
    check("cd_no_play", 32'(playEnable), 0);
    do_tick();
    check("play_restart", 32'(restartGame), 1);
    check("play_en", 32'(playEnable), 1);
    check("play_state", 32'(dut.state_q), 32'(StPlay));
    cycle();
    check("restart_one_cycle", 32'(restartGame), 0);
    check("play_en_held", 32'(playEnable), 1);

    // round 1: left wins, with a coincident tick that must not touch the hold count
    tick = 1'b1;
    do_win(1'b1, 1'b0);
    tick = 1'b0;
    check("r1_score_l", 32'(scoreL), 1);
    check("r1_state", 32'(dut.state_q), 32'(StRoundOver));
    check("r1_cnt_hold", 32'(dut.cnt_q), 2);
    check("r1_play_off", 32'(playEnable), 0);
    do_win(1'b1, 1'b0);
    check("ro_left_ignored", 32'(scoreL), 1);
    do_start();
    check("ro_start_ignored", 32'(dut.state_q), 32'(StRoundOver));
    hold();
    check("r1_back_cd", 32'(dut.state_q), 32'(StCountdown));
    check("r1_reload", 32'(dut.cnt_q), 3);

    // round 2: left wins
    to_play();
    do_win(1'b1, 1'b0);
    check("r2_score_l", 32'(scoreL), 2);
    hold();

    // round 3: draw
    to_play();
    do_win(1'b1, 1'b1);
    check("draw_score_l", 32'(scoreL), 2);
    check("draw_score_r", 32'(scoreR), 0);
    check("draw_state", 32'(dut.state_q), 32'(StRoundOver));
    hold();
    check("draw_then_cd", 32'(dut.state_q), 32'(StCountdown));

    // round 4: right wins
    to_play();
    do_win(1'b0, 1'b1);
    check("r4_score_r", 32'(scoreR), 1);
    hold();

    // round 5: left reaches 3 and takes the match after the hold
    to_play();
    do_win(1'b1, 1'b0);
    check("r5_score_l", 32'(scoreL), 3);
    do_tick();
    do_tick();
    check("r5_winner_pending", 32'(winner), 0);
    do_tick();
    check("match_state", 32'(dut.state_q), 32'(StMatchOver));
    check("match_winner", 32'(winner), 32'(WIN_LEFT));
    check("match_play_off", 32'(playEnable), 0);
    do_win(1'b1, 1'b0);
    check("mo_left_ignored", 32'(scoreL), 3);
    do_tick();
    check("mo_winner_held", 32'(winner), 1);

    // new match clears everything
    do_start();
    check("new_score_l", 32'(scoreL), 0);
    check("new_score_r", 32'(scoreR), 0);
    check("new_winner", 32'(winner), 0);
    check("new_state", 32'(dut.state_q), 32'(StCountdown));

    // get right to 2, then reset mid-play
    to_play();
    do_win(1'b0, 1'b1);
    hold();
    to_play();
    do_win(1'b0, 1'b1);
    check("pre_rst_score_r", 32'(scoreR), 2);
    hold();
    to_play();
    check("pre_rst_play", 32'(playEnable), 1);
    Reset = 1'b1; rightWin = 1'b1; tick = 1'b1; start = 1'b1;
    cycle();
    Reset = 1'b0; rightWin = 1'b0; tick = 1'b0; start = 1'b0;
    check_idle_outputs("mid_play_rst");
    check("mid_play_rst_cnt", 32'(dut.cnt_q), 0);

`ifdef ROUND_TIMEOUT_EN
    do_start();
    to_play();
    repeat (4) do_tick();
    check("to_still_play", 32'(dut.state_q), 32'(StPlay));
    do_tick();
    check("to_state", 32'(dut.state_q), 32'(StRoundOver));
    check("to_score_l", 32'(scoreL), 0);
    check("to_score_r", 32'(scoreR), 0);
    hold();
    to_play();
    repeat (4) do_tick();
    tick = 1'b1;
    do_win(1'b1, 1'b0);
    tick = 1'b0;
    check("to_win_priority", 32'(scoreL), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
